// File: rtl/fpa_result_collector.sv
// fpa_result_collector: show-ahead FIFO that captures pipelined FP adder results for a valid/ready consumer
// Ports: clk, rst (async, active-high); in_result/in_ready from the adder (no stall, one word per strobe);
//   out_data/out_valid/out_ready to the consumer; clear zeroes overflow and result_count;
//   level/full/empty report fill; overflow is sticky on a dropped result; result_count counts accepted pushes.
//   Defining FPA_CLASSIFY_EN adds out_class (zero/subnormal/inf/NaN of the head word) and sticky nan_seen.
module fpa_result_collector #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       in_result,
  input  logic                   in_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  input  logic                   clear,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow,
  output logic [CNT_W-1:0]       result_count
`ifdef FPA_CLASSIFY_EN
  ,
  output logic [3:0]             out_class,
  output logic                   nan_seen
`endif
);
  localparam int AW = $clog2(DEPTH);
`ifdef FPA_CLASSIFY_EN
  localparam int SW = WIDTH + 4;
`else
  localparam int SW = WIDTH;
`endif
  logic [SW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [SW-1:0] wr_word;
  logic pop, push, drop;
  assign empty     = level == '0;
  assign full      = level == (AW+1)'(DEPTH);
  assign out_valid = !empty;
  assign pop       = out_valid & out_ready;
  // a pop on the same edge frees a slot, so a full FIFO still accepts the word
  assign push      = in_ready & (!full | pop);
  assign drop      = in_ready & full & !pop;
`ifdef FPA_CLASSIFY_EN
  logic [10:0] in_exp;
  logic [51:0] in_mant;
  logic [3:0]  in_class;
  assign in_exp    = in_result[62:52];
  assign in_mant   = in_result[51:0];
  assign in_class  = {&in_exp & |in_mant, &in_exp & ~|in_mant, ~|in_exp & |in_mant, ~|in_exp & ~|in_mant};
  assign wr_word   = {in_class, in_result};
  assign out_class = empty ? '0 : mem[rd_ptr][WIDTH+:4];
  always_ff @(posedge clk or posedge rst)
    if (rst) nan_seen <= 1'b0;
    else nan_seen <= (push & in_class[3]) | (nan_seen & !clear);
`else
  assign wr_word   = in_result;
`endif
  // stale entries stay in memory after reset; the empty gate hides them
  assign out_data = empty ? '0 : mem[rd_ptr][WIDTH-1:0];
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wr_word;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      overflow     <= 1'b0;
      result_count <= '0;
    end else begin
      wr_ptr       <= wr_ptr + AW'(push);
      rd_ptr       <= rd_ptr + AW'(pop);
      level        <= level + (AW+1)'(push) - (AW+1)'(pop);
      overflow     <= drop | (overflow & !clear);
      result_count <= (clear ? '0 : result_count) + CNT_W'(push);
    end
endmodule

// File: tb/tb_fpa_result_collector.sv
// tb_fpa_result_collector: table, directed and random checks of fpa_result_collector against a queue model
module tb_fpa_result_collector;
  localparam int DEPTH = 8;
  localparam int CNT_W = 4;
  logic        clk = 1'b0, rst = 1'b1;
  logic [63:0] in_result = '0;
  logic        in_ready = 1'b0, out_ready = 1'b0, clear = 1'b0;
  logic [63:0] out_data;
  logic        out_valid, full, empty, overflow;
  logic [3:0]  level;
  logic [CNT_W-1:0] result_count;
`ifdef FPA_CLASSIFY_EN
  logic [3:0]  out_class;
  logic        nan_seen;
`endif
  int n_chk = 0, n_fail = 0;
  logic [63:0] q[$];
  int          m_cnt = 0;
  logic        m_ovf = 1'b0, m_nan = 1'b0;

  fpa_result_collector #(.WIDTH(64), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_result(in_result), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .clear(clear),
    .level(level), .full(full), .empty(empty), .overflow(overflow), .result_count(result_count)
`ifdef FPA_CLASSIFY_EN
    , .out_class(out_class), .nan_seen(nan_seen)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] cls(input logic [63:0] w);
    logic [10:0] e;
    logic [51:0] m;
    e = w[62:52];
    m = w[51:0];
    return {e == 11'h7FF && m != 0, e == 11'h7FF && m == 0, e == 0 && m != 0, e == 0 && m == 0};
  endfunction

  task automatic check_all();
    int n;
    n = q.size();
    chk("out_valid", 64'(out_valid), 64'(n > 0));
    chk("out_data", out_data, n > 0 ? q[0] : 64'h0);
    chk("level", 64'(level), 64'(n));
    chk("full", 64'(full), 64'(n == DEPTH));
    chk("empty", 64'(empty), 64'(n == 0));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("result_count", 64'(result_count), 64'(m_cnt));
`ifdef FPA_CLASSIFY_EN
    chk("out_class", 64'(out_class), 64'(n > 0 ? cls(q[0]) : 4'h0));
    chk("nan_seen", 64'(nan_seen), 64'(m_nan));
`endif
  endtask

  // one clock: drive inputs, step the model by the same rules, compare after the edge
  task automatic cycle(input logic [63:0] d, input logic ir, input logic ordy, input logic clr);
    logic mpop, mpush;
    logic [3:0] c;
    in_result = d; in_ready = ir; out_ready = ordy; clear = clr;
    mpop  = ordy && q.size() > 0;
    mpush = ir && (q.size() < DEPTH || mpop);
    c = cls(d);
    @(posedge clk);
    if (mpop) void'(q.pop_front());
    if (mpush) q.push_back(d);
    if (clr) m_cnt = 0;
    if (mpush) m_cnt = (m_cnt + 1) % (1 << CNT_W);
    m_ovf = (ir && !mpush) || (m_ovf && !clr);
    m_nan = (mpush && c[3]) || (m_nan && !clr);
    #1;
    in_ready = 1'b0; out_ready = 1'b0; clear = 1'b0; in_result = '0;
    check_all();
  endtask

  typedef struct {
    logic [63:0] d;
    logic        ir, ordy, clr, ev;
    logic [63:0] ed;
    logic [3:0]  el;
    logic        eo;
    logic [3:0]  ec;
  } vec_t;

  initial begin
    vec_t tbl[9];
    logic [63:0] exp_w[8];
    tbl[0] = '{64'h4066800000000000, 1'b1, 1'b1, 1'b0, 1'b1, 64'h4066800000000000, 4'd1, 1'b0, 4'd1};
    tbl[1] = '{64'h0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 4'd0, 1'b0, 4'd1};
    tbl[2] = '{64'hAAAA, 1'b1, 1'b0, 1'b0, 1'b1, 64'hAAAA, 4'd1, 1'b0, 4'd2};
    tbl[3] = '{64'hBBBB, 1'b1, 1'b0, 1'b0, 1'b1, 64'hAAAA, 4'd2, 1'b0, 4'd3};
    tbl[4] = '{64'hCCCC, 1'b1, 1'b1, 1'b0, 1'b1, 64'hBBBB, 4'd2, 1'b0, 4'd4};
    tbl[5] = '{64'h0, 1'b0, 1'b1, 1'b0, 1'b1, 64'hCCCC, 4'd1, 1'b0, 4'd4};
    tbl[6] = '{64'h0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 4'd0, 1'b0, 4'd4};
    tbl[7] = '{64'h0, 1'b0, 1'b1, 1'b1, 1'b0, 64'h0, 4'd0, 1'b0, 4'd0};
    tbl[8] = '{64'h0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 4'd0, 1'b0, 4'd0};

    @(posedge clk); #1;
    chk("rst_valid", 64'(out_valid), 64'h0);
    chk("rst_empty", 64'(empty), 64'h1);
    chk("rst_full", 64'(full), 64'h0);
    chk("rst_data", out_data, 64'h0);
    check_all();
    #2 rst = 1'b0;

    foreach (tbl[i]) begin
      cycle(tbl[i].d, tbl[i].ir, tbl[i].ordy, tbl[i].clr);
      chk($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'(tbl[i].ev));
      chk($sformatf("tbl%0d_data", i), out_data, tbl[i].ed);
      chk($sformatf("tbl%0d_level", i), 64'(level), 64'(tbl[i].el));
      chk($sformatf("tbl%0d_ovf", i), 64'(overflow), 64'(tbl[i].eo));
      chk($sformatf("tbl%0d_cnt", i), 64'(result_count), 64'(tbl[i].ec));
    end

    for (int i = 0; i < 8; i++) cycle(64'h1000 + 64'(i), 1'b1, 1'b0, 1'b0);
    chk("fill_full", 64'(full), 64'h1);
    chk("fill_level", 64'(level), 64'h8);
    cycle(64'hDEAD, 1'b1, 1'b0, 1'b0);
    chk("drop_ovf", 64'(overflow), 64'h1);
    chk("drop_level", 64'(level), 64'h8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain%0d", i), out_data, 64'h1000 + 64'(i));
      cycle(64'h0, 1'b0, 1'b1, 1'b0);
    end
    chk("drain_empty", 64'(empty), 64'h1);
    chk("drain_cnt", 64'(result_count), 64'h8);
    cycle(64'h0, 1'b0, 1'b0, 1'b1);
    chk("clear_ovf", 64'(overflow), 64'h0);

    for (int i = 0; i < 8; i++) cycle(64'h2000 + 64'(i), 1'b1, 1'b0, 1'b0);
    for (int j = 0; j < 3; j++) begin
      cycle(64'h3000 + 64'(j), 1'b1, 1'b1, 1'b0);
      chk($sformatf("pp%0d_level", j), 64'(level), 64'h8);
      chk($sformatf("pp%0d_ovf", j), 64'(overflow), 64'h0);
    end
    for (int i = 0; i < 8; i++) exp_w[i] = i < 5 ? 64'h2003 + 64'(i) : 64'h3000 + 64'(i - 5);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("wrap%0d", i), out_data, exp_w[i]);
      cycle(64'h0, 1'b0, 1'b1, 1'b0);
    end

    for (int i = 0; i < 3; i++) cycle(64'h5000 + 64'(i), 1'b1, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    q.delete(); m_cnt = 0; m_ovf = 1'b0; m_nan = 1'b0;
    chk("mrst_valid", 64'(out_valid), 64'h0);
    chk("mrst_level", 64'(level), 64'h0);
    chk("mrst_empty", 64'(empty), 64'h1);
    chk("mrst_data", out_data, 64'h0);
    #2 rst = 1'b0;
    cycle(64'h6000, 1'b1, 1'b0, 1'b0);
    chk("post_rst_data", out_data, 64'h6000);
    cycle(64'h6001, 1'b1, 1'b1, 1'b0);
    chk("post_rst_data2", out_data, 64'h6001);
    cycle(64'h0, 1'b0, 1'b1, 1'b1);

    for (int i = 0; i < 17; i++) cycle(64'h7000 + 64'(i), 1'b1, 1'b1, 1'b0);
    chk("cnt_wrap", 64'(result_count), 64'h1);
    cycle(64'h7100, 1'b1, 1'b0, 1'b1);
    chk("clr_push_cnt", 64'(result_count), 64'h1);
    for (int i = 0; i < 16 && q.size() < DEPTH; i++) cycle(64'h7200 + 64'(i), 1'b1, 1'b0, 1'b0);
    cycle(64'h7300, 1'b1, 1'b0, 1'b1);
    chk("clr_drop_ovf", 64'(overflow), 64'h1);
    chk("clr_drop_cnt", 64'(result_count), 64'h0);

    for (int i = 0; i < 400; i++)
      cycle({$urandom, $urandom}, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);

    for (int i = 0; i < 16 && q.size() > 0; i++) cycle(64'h0, 1'b0, 1'b1, 1'b0);
    cycle(64'h0, 1'b0, 1'b0, 1'b1);
`ifdef FPA_CLASSIFY_EN
    begin
      logic [63:0] cw[4];
      logic [3:0]  cc[4];
      cw = '{64'h7FF8000000000000, 64'h0000000000000000, 64'h7FF0000000000000, 64'h0000000000000001};
      cc = '{4'b1000, 4'b0001, 4'b0100, 4'b0010};
      for (int i = 0; i < 4; i++) begin
        cycle(cw[i], 1'b1, 1'b0, 1'b0);
        chk($sformatf("nan_seen%0d", i), 64'(nan_seen), 64'h1);
      end
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("class%0d", i), 64'(out_class), 64'(cc[i]));
        cycle(64'h0, 1'b0, 1'b1, 1'b0);
      end
      chk("class_empty", 64'(out_class), 64'h0);
    end
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fpa_result_collector.md
Name: fpa_result_collector

Overview:
- Downstream stage of the pipelined 64-bit floating-point adder (pipeFPA32).
- The adder has no stall input and emits one result per cycle, qualified by its ready strobe.
- This block captures every qualified result into a small show-ahead FIFO and presents it on a valid/ready handshake to the consumer.
- It also reports fill level, a sticky overflow flag for dropped results and a running count of accepted results.

Parameters:
- WIDTH, 64, result word width (IEEE-754 double).
- DEPTH, 8, FIFO entries; must be a power of two, at least 2.
- CNT_W, 16, width of the accepted-result counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- in_result  input  WIDTH  result word from the adder.
- in_ready  input  1  adder result-valid strobe; one result per high cycle.
- out_data  output  WIDTH  head-of-FIFO word.
- out_valid  output  1  head entry present.
- out_ready  input  1  consumer accepts the head this cycle.
- clear  input  1  synchronous clear of overflow and result_count only.
- level  output  $clog2(DEPTH)+1  current number of entries.
- full  output  1  level == DEPTH.
- empty  output  1  level == 0.
- overflow  output  1  sticky: a result was dropped.
- result_count  output  CNT_W  number of accepted pushes, modulo 2^CNT_W.

Behaviour:
- Reset: clk and rst are the only clock and reset. Reset is asynchronous and active-high, and takes effect immediately, including mid-operation.
- Reset values: pointers = 0, level = 0, empty = 1, full = 0, out_valid = 0, out_data = 0, overflow = 0, result_count = 0. Stored entries are discarded.
- Pop: occurs on a rising edge when out_valid && out_ready. out_ready while empty has no effect.
- Push: occurs when in_ready && (!full || pop in the same cycle). The word is written at the write pointer and the pointer advances, wrapping at DEPTH.
- Drop: in_ready && full && no pop. The word is discarded and overflow is set on that edge. Level, pointers and count are unchanged.
- Latency: a word pushed at edge N appears on out_data with out_valid = 1 after edge N. There is no same-cycle bypass.
- Show-ahead: out_data always equals the head entry while out_valid = 1, and is stable until popped. When empty, out_data = 0.
- Level: push only → +1; pop only → −1; push and pop together → unchanged, including when full or at level 1.
- Ordering: strict FIFO order with no reordering. Pointer wrap-around is transparent to the consumer.
- result_count: +1 per accepted push; wraps from 2^CNT_W−1 to 0. Drops are not counted.
- clear: zeroes overflow and result_count on the edge. FIFO contents are untouched.
- clear vs. event: if clear coincides with a drop, overflow ends at 1 (the new event wins). If clear coincides with an accepted push, result_count ends at 1.
- Registered outputs: out_valid, full, empty and level are registered or derived only from registered state. There is no combinational path from in_ready to any output.

Optional Feature:
- Macro: FPA_CLASSIFY_EN.
- When defined:
  - Adds output out_class [3:0], valid with out_data.
  - The class is computed from in_result at push time and stored with the entry, so storage is WIDTH+4 bits.
  - Encoding (exponent = bits 62:52, mantissa = bits 51:0):
    - bit0 zero: exp == 0, mant == 0.
    - bit1 subnormal: exp == 0, mant != 0.
    - bit2 infinity: exp all-ones, mant == 0.
    - bit3 NaN: exp all-ones, mant != 0.
  - Adds output nan_seen: sticky, set on any accepted NaN push, cleared by rst or clear (the same-cycle event wins).
  - out_class = 0 when empty.
- When undefined: out_class and nan_seen do not exist, storage is WIDTH bits, and all other behaviour is identical.

Test Plan:
- Single result: in_result = 64'h4066800000000000 with in_ready high for one cycle and out_ready = 1 → after the push edge out_valid = 1 and out_data = 64'h4066800000000000; after the next edge empty = 1 and result_count = 1.
- Fill and overflow: out_ready = 0, push 8 distinct words → full = 1, level = 8. A 9th push is dropped and overflow = 1. Draining returns exactly the first 8 words in order, with result_count = 8.
- Full with simultaneous push and pop: with level = 8, out_ready = 1 and in_ready = 1 for 3 cycles → level stays 8, overflow stays 0, and output order is preserved across pointer wrap.
- Mid-operation reset: push 3 words, then assert rst between clock edges → out_valid = 0, level = 0, empty = 1 and out_data = 0 before the next edge. Pushes after release behave normally.
- Counter and clear (CNT_W = 4): 17 pushes → result_count = 1. clear together with a push → result_count = 1. clear together with a drop → overflow = 1.
- Classify (FPA_CLASSIFY_EN defined): push 64'h7FF8000000000000, 64'h0000000000000000, 64'h7FF0000000000000 and 64'h0000000000000001 → out_class = 4'b1000, 4'b0001, 4'b0100, 4'b0010 respectively, and nan_seen = 1 from the first push onward.
